// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register map, field positions and the UART FSM state type
// shared by the transmit and receive channels.
package apb_uart_pkg;
    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_CFG    = 3'd2;
    localparam logic [2:0] A_BAUD   = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    localparam int CFG_STOP = 2;
    localparam int CFG_PEN  = 3;
    localparam int CFG_ODD  = 4;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_PERR     = 3;
    localparam int ST_FERR     = 4;
    localparam int ST_OVR      = 5;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    // Index of the last data bit for a CFG[1:0] length code (5..8 bits).
    function automatic logic [2:0] last_bit(input logic [1:0] len);
        return 3'd4 + {1'b0, len};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] len);
        return 8'hFF >> (2'd3 - len);
    endfunction
endpackage

// File: rtl/apb_uart_bitgen.sv
// apb_uart_bitgen: bit-period counter; tick_o ends each bit period,
// half_o marks the middle of the period after a load.
module apb_uart_bitgen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [15:0] div_i,
    output logic        tick_o,
    output logic        half_o
);
    logic [15:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == div_i - 16'd1;
    assign half_o = cnt_q == (div_i >> 1) - 16'd1;
    assign cnt_d  = (load_i || tick_o) ? 16'd0 : cnt_q + 16'd1;

    always_ff @(posedge clk) cnt_q <= reset_n ? 16'd0 : cnt_d;
endmodule

// File: rtl/apb_uart.sv
// apb_uart: APB slave UART with single-entry TX/RX buffers, programmable
// frame format and baud divisor, and optional RTS/CTS flow control.
module apb_uart
    import apb_uart_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DIV_RESET = 434
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        pstrb,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       prdata,
    input  logic              rx,
    input  logic              cts_n,
    output logic              tx,
    output logic              rts_n
);
    logic [2:0]  a;
    logic        acc, err, wr, wr_tx, rd_rx, rd_st;
    logic [4:0]  cfg_q;
    logic [15:0] baud_q, div_eff;
    logic        ctrl_q, rts_q;
    logic [7:0]  txbuf_q, rx_data_q;
    logic        tx_full_q, rx_valid_q, perr_q, ferr_q, ovr_q;
    logic        rx_s1_q, rx_s_q, rx_last_q, cts_s1_q, cts_s_q;
    logic [31:0] status, rdata;
    uart_state_t tx_st_q, rx_st_q;
    logic [7:0]  tx_sh_q, rx_sh_q;
    logic [2:0]  tx_cnt_q, rx_cnt_q;
    logic        tx_q, tx_par_q, rx_par_q, rx_perr_q;
    logic [4:0]  tx_cfg_q, rx_cfg_q;
    logic [15:0] tx_div_q, rx_div_q;
    logic        tx_start, tx_tick, tx_unused_half;
    logic        rx_fall, rx_load, rx_done, rx_tick, rx_half;
    logic        unused;

    assign a   = paddr[4:2];
    assign acc = psel & penable;
    assign err = (a > A_STATUS)
               | (pwrite & ((a == A_RXDATA) | (a == A_STATUS)))
               | (pwrite & (a == A_TXDATA) & tx_full_q)
               | (!pwrite & (a == A_RXDATA) & !rx_valid_q);
    assign wr    = acc & pwrite & !err;
    assign wr_tx = wr & (a == A_TXDATA) & pstrb[0];
    assign rd_rx = acc & !pwrite & !err & (a == A_RXDATA);
    assign rd_st = acc & !pwrite & (a == A_STATUS);

    always_comb begin
        status              = '0;
        status[ST_TX_BUSY]  = tx_st_q != IDLE;
        status[ST_TX_FULL]  = tx_full_q;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_PERR]     = perr_q;
        status[ST_FERR]     = ferr_q;
        status[ST_OVR]      = ovr_q;
    end

    assign rdata = (a == A_RXDATA) ? {24'd0, rx_data_q} :
                   (a == A_CFG)    ? {27'd0, cfg_q} :
                   (a == A_BAUD)   ? {16'd0, baud_q} :
                   (a == A_CTRL)   ? {31'd0, ctrl_q} :
                   (a == A_STATUS) ? status : 32'd0;

    assign pready  = 1'b1;
    assign pslverr = acc & err;
    assign prdata  = (acc & !pwrite & !err) ? rdata : 32'd0;
    assign tx      = tx_q;
    assign rts_n   = rts_q;
    assign div_eff = (baud_q < 16'd4) ? 16'd4 : baud_q;
    assign unused  = ^{paddr[ADDR_W-1:5], paddr[1:0], pstrb[3:2], pwdata[31:16],
                       rx_cfg_q[CFG_STOP], tx_unused_half};

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cfg_q      <= 5'h03;
            baud_q     <= 16'(DIV_RESET);
            ctrl_q     <= 1'b0;
            txbuf_q    <= '0;
            tx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rts_q      <= 1'b1;
            {rx_last_q, rx_s_q, rx_s1_q} <= 3'b111;
            {cts_s_q, cts_s1_q}          <= 2'b11;
        end else begin
            if (wr && a == A_CFG && pstrb[0]) cfg_q <= pwdata[4:0];
            if (wr && a == A_BAUD && pstrb[0]) baud_q[7:0] <= pwdata[7:0];
            if (wr && a == A_BAUD && pstrb[1]) baud_q[15:8] <= pwdata[15:8];
            if (wr && a == A_CTRL && pstrb[0]) ctrl_q <= pwdata[0];
            if (wr_tx) txbuf_q <= pwdata[7:0];
            if (rx_done) rx_data_q <= rx_sh_q;
            tx_full_q  <= wr_tx | (tx_full_q & !tx_start);
            // A completing frame beats a same-edge RXDATA read, without overrun.
            rx_valid_q <= rx_done | (rx_valid_q & !rd_rx);
            perr_q     <= (perr_q & !rd_st) | (rx_done & rx_perr_q);
            ferr_q     <= (ferr_q & !rd_st) | (rx_done & !rx_s_q);
            ovr_q      <= (ovr_q & !rd_st) | (rx_done & rx_valid_q & !rd_rx);
            rts_q      <= ctrl_q & rx_valid_q;
            {rx_last_q, rx_s_q, rx_s1_q} <= {rx_s_q, rx_s1_q, rx};
            {cts_s_q, cts_s1_q}          <= {cts_s1_q, cts_n};
        end
    end

    assign tx_start = (tx_st_q == IDLE) & tx_full_q & (!ctrl_q | !cts_s_q);

    apb_uart_bitgen u_tx_bit (
        .clk(clk), .reset_n(reset_n), .load_i(tx_start), .div_i(tx_div_q),
        .tick_o(tx_tick), .half_o(tx_unused_half)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            tx_st_q  <= IDLE;
            tx_q     <= 1'b1;
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
            tx_par_q <= 1'b0;
            tx_cfg_q <= '0;
            tx_div_q <= 16'd4;
        end else begin
            case (tx_st_q)
                IDLE: if (tx_start) begin
                    tx_st_q  <= START;
                    tx_q     <= 1'b0;
                    tx_sh_q  <= txbuf_q;
                    tx_cnt_q <= '0;
                    tx_cfg_q <= cfg_q;
                    tx_div_q <= div_eff;
                    tx_par_q <= ^(txbuf_q & data_mask(cfg_q[1:0])) ^ cfg_q[CFG_ODD];
                end
                START: if (tx_tick) begin
                    tx_st_q <= DATA;
                    tx_q    <= tx_sh_q[0];
                    tx_sh_q <= tx_sh_q >> 1;
                end
                DATA: if (tx_tick) begin
                    if (tx_cnt_q == last_bit(tx_cfg_q[1:0])) begin
                        tx_st_q  <= tx_cfg_q[CFG_PEN] ? PARITY : STOP;
                        tx_q     <= tx_cfg_q[CFG_PEN] ? tx_par_q : 1'b1;
                        tx_cnt_q <= '0;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_cnt_q <= tx_cnt_q + 3'd1;
                    end
                end
                PARITY: if (tx_tick) begin
                    tx_st_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: if (tx_tick) begin
                    tx_st_q  <= (tx_cfg_q[CFG_STOP] && tx_cnt_q == 3'd0) ? STOP : IDLE;
                    tx_cnt_q <= tx_cnt_q + 3'd1;
                end
                default: tx_st_q <= IDLE;
            endcase
        end
    end

    assign rx_fall = rx_last_q & !rx_s_q;
    // Reload at mid-start so later ticks land mid-bit.
    assign rx_load = ((rx_st_q == IDLE) & rx_fall) | ((rx_st_q == START) & rx_half);
    assign rx_done = (rx_st_q == STOP) & rx_tick;

    apb_uart_bitgen u_rx_bit (
        .clk(clk), .reset_n(reset_n), .load_i(rx_load), .div_i(rx_div_q),
        .tick_o(rx_tick), .half_o(rx_half)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            rx_st_q   <= IDLE;
            rx_sh_q   <= '0;
            rx_cnt_q  <= '0;
            rx_par_q  <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_cfg_q  <= '0;
            rx_div_q  <= 16'd4;
        end else begin
            case (rx_st_q)
                IDLE: if (rx_fall) begin
                    rx_st_q   <= START;
                    rx_sh_q   <= '0;
                    rx_cnt_q  <= '0;
                    rx_par_q  <= 1'b0;
                    rx_perr_q <= 1'b0;
                    rx_cfg_q  <= cfg_q;
                    rx_div_q  <= div_eff;
                end
                START: if (rx_half) rx_st_q <= rx_s_q ? IDLE : DATA;
                DATA: if (rx_tick) begin
                    rx_sh_q[rx_cnt_q] <= rx_s_q;
                    rx_par_q          <= rx_par_q ^ rx_s_q;
                    rx_cnt_q          <= rx_cnt_q + 3'd1;
                    if (rx_cnt_q == last_bit(rx_cfg_q[1:0]))
                        rx_st_q <= rx_cfg_q[CFG_PEN] ? PARITY : STOP;
                end
                PARITY: if (rx_tick) begin
                    rx_st_q   <= STOP;
                    rx_perr_q <= rx_s_q != (rx_par_q ^ rx_cfg_q[CFG_ODD]);
                end
                STOP: if (rx_tick) rx_st_q <= IDLE;
                default: rx_st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: randomized and directed checks of apb_uart against a
// frame-level reference model of the serial line and register behaviour.
module tb_apb_uart;
    localparam logic [11:0] TXD = 12'h00, RXD = 12'h04, CFG = 12'h08;
    localparam logic [11:0] BAUD = 12'h0C, CTRL = 12'h10, STAT = 12'h14;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstrb = '0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0, prdata;
    logic        pready, pslverr, rx, tx, rts_n;
    logic        cts_n = 1'b0, loop = 1'b1, rx_drv = 1'b1;
    int          n_chk = 0, n_err = 0;
    logic        exp_bits[$];

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    apb_uart dut (
        .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .prdata(prdata), .rx(rx), .cts_n(cts_n), .tx(tx), .rts_n(rts_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); r = prdata; e = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic e_exp = 1'b0, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        logic e;
        apb(1'b1, a, d, s, r, e);
        check($sformatf("wr%0h_err", a), {31'd0, e}, {31'd0, e_exp});
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a,
                          input logic [31:0] exp, input logic e_exp = 1'b0);
        logic [31:0] r;
        logic e;
        apb(1'b0, a, 32'd0, 4'h0, r, e);
        check({tag, "_data"}, r, exp);
        check({tag, "_err"}, {31'd0, e}, {31'd0, e_exp});
    endtask

    // Reference serial frame: start, LSB-first data, optional parity, 1 or 2 stops.
    function automatic void make_frame(input logic [7:0] d, input logic [4:0] c);
        int n = 5 + int'(c[1:0]);
        int ones = 0;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (c[3]) exp_bits.push_back((ones % 2 == 1) != c[4]);
        exp_bits.push_back(1'b1);
        if (c[2]) exp_bits.push_back(1'b1);
    endfunction

    function automatic logic [31:0] rx_byte(input logic [7:0] d, input logic [4:0] c);
        return 32'(int'(d) % (1 << (5 + int'(c[1:0]))));
    endfunction

    task automatic tx_frame(input string tag, input logic [7:0] d, input logic [4:0] c, input int div);
        bit seen = 1'b0;
        make_frame(d, c);
        for (int t = 0; t < 600 && !seen; t++) begin
            @(negedge clk);
            seen = !tx;
        end
        check({tag, "_start"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            repeat (div / 2) @(negedge clk);
            foreach (exp_bits[i]) begin
                check($sformatf("%s_bit%0d", tag, i), {31'd0, tx}, {31'd0, exp_bits[i]});
                repeat (div) @(negedge clk);
            end
        end
    endtask

    task automatic send_rx(input int div);
        foreach (exp_bits[i]) begin
            rx_drv = exp_bits[i];
            repeat (div) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (2 * div) @(posedge clk);
        #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_rts", {31'd0, rts_n}, 32'd1);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("pready", {31'd0, pready}, 32'd1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_rts", {31'd0, rts_n}, 32'd0);
        rd_chk("cfg_rst", CFG, 32'h03);
        rd_chk("baud_rst", BAUD, 32'd434);
        rd_chk("status_rst", STAT, 32'h00);
        rd_chk("ctrl_rst", CTRL, 32'h00);
        rd_chk("txdata_rd", TXD, 32'h00);

        // 8N1 loopback of 0xA5
        wr(BAUD, 32'd8);
        wr(TXD, 32'hA5);
        rd_chk("busy", STAT, 32'h01);
        tx_frame("a5", 8'hA5, 5'h03, 8);
        rd_chk("a5_st", STAT, 32'h04);
        rd_chk("a5_rx", RXD, 32'hA5);

        // 7O2 loopback of 0x35
        wr(CFG, 32'h1E);
        wr(TXD, 32'h35);
        tx_frame("o72", 8'h35, 5'h1E, 8);
        rd_chk("o72_st", STAT, 32'h04);
        rd_chk("o72_rx", RXD, 32'h35);

        // Random formats, divisors (incl. clamped ones below 4) and bytes
        for (int k = 0; k < 8; k++) begin
            int raw = int'($urandom_range(1, 16));
            int div = raw < 4 ? 4 : raw;
            logic [4:0] c = 5'($urandom);
            logic [7:0] d = 8'($urandom);
            wr(BAUD, 32'(raw));
            wr(CFG, {27'd0, c});
            wr(TXD, {24'd0, d});
            tx_frame($sformatf("rnd%0d", k), d, c, div);
            rd_chk($sformatf("rnd%0d_st", k), STAT, 32'h04);
            rd_chk($sformatf("rnd%0d_rx", k), RXD, rx_byte(d, c));
        end

        // Parity and framing errors on externally driven frames (8E1)
        loop = 1'b0;
        wr(BAUD, 32'd8);
        wr(CFG, 32'h0B);
        make_frame(8'h01, 5'h0B);
        exp_bits[9] = !exp_bits[9];
        send_rx(8);
        rd_chk("perr_st", STAT, 32'h0C);
        rd_chk("perr_rx", RXD, 32'h01);
        make_frame(8'h5A, 5'h0B);
        exp_bits[10] = 1'b0;
        send_rx(8);
        rd_chk("ferr_st", STAT, 32'h14);
        rd_chk("ferr_st2", STAT, 32'h04);
        rd_chk("ferr_rx", RXD, 32'h5A);
        rd_chk("err_clr", STAT, 32'h00);

        // Overrun with RTS flow control
        wr(CFG, 32'h03);
        wr(CTRL, 32'h1);
        make_frame(8'h11, 5'h03);
        send_rx(8);
        check("rts_full", {31'd0, rts_n}, 32'd1);
        make_frame(8'h22, 5'h03);
        send_rx(8);
        rd_chk("ovr_st", STAT, 32'h24);
        rd_chk("ovr_rx", RXD, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        check("rts_empty", {31'd0, rts_n}, 32'd0);

        // CTS hold-off: frame waits for cts_n low
        cts_n = 1'b1;
        wr(TXD, 32'h77);
        begin
            bit low = 1'b0;
            repeat (40) begin
                @(negedge clk);
                low |= !tx;
            end
            check("cts_hold", {31'd0, low}, 32'd0);
        end
        rd_chk("cts_st", STAT, 32'h02);
        cts_n = 1'b0;
        tx_frame("cts", 8'h77, 5'h03, 8);
        wr(CTRL, 32'h0);

        // Byte lanes
        wr(BAUD, 32'h0000_0010);
        wr(BAUD, 32'h0000_09FF, 1'b0, 4'b0010);
        rd_chk("baud_lane", BAUD, 32'h0910);
        wr(CFG, 32'h0000_001F, 1'b0, 4'b0000);
        rd_chk("cfg_nolane", CFG, 32'h03);
        wr(BAUD, 32'd16);

        // APB error responses leave state untouched
        loop = 1'b1;
        wr(STAT, 32'hFF, 1'b1);
        rd_chk("unmapped_rd", 12'h1C, 32'h0, 1'b1);
        wr(12'h18, 32'hFF, 1'b1);
        wr(RXD, 32'hFF, 1'b1);
        rd_chk("rx_empty", RXD, 32'h0, 1'b1);
        wr(TXD, 32'h12);
        wr(TXD, 32'h34);
        wr(TXD, 32'h56, 1'b1);
        rd_chk("full_st", STAT, 32'h03);
        rd_chk("cfg_kept", CFG, 32'h03);
        rd_chk("baud_kept", BAUD, 32'd16);
        repeat (450) @(posedge clk);
        #1;
        rd_chk("two_st", STAT, 32'h24);
        rd_chk("two_rx", RXD, 32'h34);

        // Reset mid-frame
        wr(TXD, 32'hAA);
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("midrst_st", STAT, 32'h00);
        rd_chk("midrst_baud", BAUD, 32'd434);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
